program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter portSize, default 4: instruction-memory address width; capacity 2^portSize opcodes.
REQ-002 Parameter dataSize, default 4: opcode width; only 4 is supported.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  input  1  reset, synchronous, active-low; sampled only on the rising edge of Clk.
REQ-005 Start  input  1  one-cycle request to begin a load at address 0; ignored unless idle.
REQ-006 CharIn  input  8  ASCII program-source character.
REQ-007 CharValid  input  1  CharIn is valid this cycle.
REQ-008 CharReady  output  1  loader accepts CharIn; transfer occurs when CharValid and CharReady are both 1 on a rising edge.
REQ-009 MemAddr  output  portSize  instruction-memory write address.
REQ-010 MemData  output  dataSize  encoded opcode to write.
REQ-011 MemWrite  output  1  one-cycle write strobe for MemAddr/MemData.
REQ-012 Busy  output  1  load in progress.
REQ-013 Done  output  1  one-cycle pulse on successful end of load.
REQ-014 Error  output  1  sticky error flag; cleared by Start or reset.
REQ-015 Count  output  portSize+1  number of opcodes written in the current or last load.

Function
REQ-016 Encoding: '+'->1, '-'->2, '.'->3, '>'->4, '<'->5, '{'->6, '}'->7, '['->8, ']'->9, '0'->A, 'A'->B, ','->C, 'C'->D, 'D'->E, 'H'->F; opcode 0 is never produced from source.
REQ-017 Skipped characters (accepted, nothing written): space 0x20, tab 0x09, CR 0x0D, LF 0x0A.
REQ-018 ';' starts a comment: all following characters are accepted and discarded up to and including the next LF.
REQ-019 Terminator: '$' (0x24) or NUL (0x00) outside a comment ends the load successfully.
REQ-020 Any other character outside a comment is illegal.
REQ-021 States: IDLE, RECV, WRITE, COMMENT, DONE, ERR.
REQ-022 IDLE: CharReady=0, Busy=0; Start -> RECV, Count<=0, MemAddr<=0, Error<=0.
REQ-023 RECV: CharReady=1, Busy=1; an accepted encodable char latches its opcode into MemData -> WRITE; skipped char -> RECV; ';' -> COMMENT; terminator -> DONE; illegal char -> ERR.
REQ-024 WRITE: CharReady=0, MemWrite=1 for exactly one cycle, with MemData valid at the same time; next edge MemAddr+1 modulo 2^portSize, Count+1 -> RECV.
REQ-025 Latency: encodable char accepted on edge N -> MemWrite high in cycle N+1 -> CharReady high again in cycle N+2; throughput is one opcode per 2 cycles.
REQ-026 COMMENT: CharReady=1; LF -> RECV; every other char, including '$' and NUL, is discarded.
REQ-027 Overflow: an encodable char accepted while Count = 2^portSize -> ERR, no write; MemAddr never wraps onto written data.
REQ-028 DONE: Done=1 for one cycle, Busy=0 -> IDLE; Count and MemAddr hold their values.
REQ-029 ERR: Error=1, Busy=0, CharReady=0, no writes; stays in ERR until Start (-> RECV, with the IDLE Start initialisation) or reset.
REQ-030 Start while in RECV, WRITE or COMMENT is ignored; Start in DONE is ignored (IDLE follows next cycle).
REQ-031 MemData holds its last value while MemWrite=0.

Reset
REQ-032 Rst_n=0 at an edge -> IDLE; CharReady=0, MemWrite=0, Busy=0, Done=0, Error=0, MemAddr=0, MemData=0, Count=0.
REQ-033 Reset during WRITE aborts the pending write: MemWrite=0 from the next cycle, and no partial state is retained.
REQ-034 Reset overrides Start when both are asserted at the same edge.

Verification
REQ-035 Start, then "DA0<{<0}$" streamed with CharValid=1 continuously -> 8 writes, addr0..7 = E,B,A,5,6,5,A,7; Done pulses once; Count=8.
REQ-036 Start, then "+ \n;x$y\n-$" -> writes addr0=1, addr1=2 only; Count=2; Done pulses.
REQ-037 Start, then "+Q" -> one write (addr0=1); Error=1 after 'Q'; CharReady=0; a later Start clears Error and Count.
REQ-038 portSize=2: Start, then "+++++" -> 4 writes to addr 0..3; the 5th '+' sets Error; Count=4; no write to addr0.
REQ-039 Rst_n=0 in the cycle MemWrite=1 for the first opcode -> all outputs at their reset values next cycle; a new Start loads from addr0.
REQ-040 CharValid toggled randomly during the REQ-035 stream -> identical memory contents; no char accepted while CharReady=0.

Source files
------------

// File: rtl/program_loader_if.sv
// Character-stream and instruction-memory write signals between a program source
// and the loader. The loader takes the slave side.
interface program_loader_if #(
  parameter int portSize = 4,
  parameter int dataSize = 4
);
  logic                Start;
  logic [7:0]          CharIn;
  logic                CharValid;
  logic                CharReady;
  logic [portSize-1:0] MemAddr;
  logic [dataSize-1:0] MemData;
  logic                MemWrite;
  logic                Busy;
  logic                Done;
  logic                Error;
  logic [portSize:0]   Count;

  modport master (
    output Start, CharIn, CharValid,
    input  CharReady, MemAddr, MemData, MemWrite, Busy, Done, Error, Count
  );

  modport slave (
    input  Start, CharIn, CharValid,
    output CharReady, MemAddr, MemData, MemWrite, Busy, Done, Error, Count
  );
endinterface

// File: rtl/program_loader.sv
// Streams ASCII program source, encodes each instruction character to a 4-bit
// opcode and writes it to consecutive instruction-memory addresses.
module program_loader #(
  parameter int portSize = 4,
  parameter int dataSize = 4
) (
  input logic            Clk,
  input logic            Rst_n,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_COMMENT, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_OP, C_SKIP, C_COMMENT, C_TERM, C_ILLEGAL
  } char_class_t;

  typedef struct packed {
    char_class_t cls;
    logic [3:0]  op;
  } decode_t;

  localparam logic [portSize:0] CAPACITY = {1'b1, {portSize{1'b0}}};

  function automatic decode_t decode(input logic [7:0] c);
    decode_t d;
    d.cls = C_OP;
    d.op  = 4'h0;
    case (c)
      8'h2B: d.op = 4'h1;  // +
      8'h2D: d.op = 4'h2;  // -
      8'h2E: d.op = 4'h3;  // .
      8'h3E: d.op = 4'h4;  // >
      8'h3C: d.op = 4'h5;  // <
      8'h7B: d.op = 4'h6;  // {
      8'h7D: d.op = 4'h7;  // }
      8'h5B: d.op = 4'h8;  // [
      8'h5D: d.op = 4'h9;  // ]
      8'h30: d.op = 4'hA;  // 0
      8'h41: d.op = 4'hB;  // A
      8'h2C: d.op = 4'hC;  // ,
      8'h43: d.op = 4'hD;  // C
      8'h44: d.op = 4'hE;  // D
      8'h48: d.op = 4'hF;  // H
      8'h20, 8'h09, 8'h0D, 8'h0A: d.cls = C_SKIP;
      8'h3B:                      d.cls = C_COMMENT;
      8'h24, 8'h00:               d.cls = C_TERM;
      default:                    d.cls = C_ILLEGAL;
    endcase
    return d;
  endfunction

  state_t              state, state_next;
  logic [portSize-1:0] addr, addr_next;
  logic [dataSize-1:0] data, data_next;
  logic [portSize:0]   count, count_next;
  decode_t             dec;

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!Rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
      data  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      data  <= data_next;
      count <= count_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    addr_next  = addr;
    data_next  = data;
    count_next = count;
    dec        = decode(bus.CharIn);

    case (state)
      S_IDLE, S_ERR: begin
        if (bus.Start) begin
          state_next = S_RECV;
          addr_next  = '0;
          count_next = '0;
        end
      end
      S_RECV: begin
        if (bus.CharValid) begin
          case (dec.cls)
            C_OP: begin
              // A full memory refuses further opcodes rather than wrapping onto address 0.
              if (count == CAPACITY) begin
                state_next = S_ERR;
              end else begin
                data_next  = dataSize'(dec.op);
                state_next = S_WRITE;
              end
            end
            C_SKIP:    state_next = S_RECV;
            C_COMMENT: state_next = S_COMMENT;
            C_TERM:    state_next = S_DONE;
            default:   state_next = S_ERR;
          endcase
        end
      end
      S_WRITE: begin
        addr_next  = addr + portSize'(1);
        count_next = count + (portSize + 1)'(1);
        state_next = S_RECV;
      end
      S_COMMENT: begin
        if (bus.CharValid && bus.CharIn == 8'h0A) state_next = S_RECV;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.CharReady = (state == S_RECV) || (state == S_COMMENT);
  assign bus.MemWrite  = (state == S_WRITE);
  assign bus.Busy      = (state == S_RECV) || (state == S_WRITE) || (state == S_COMMENT);
  assign bus.Done      = (state == S_DONE);
  assign bus.Error     = (state == S_ERR);
  assign bus.MemAddr   = addr;
  assign bus.MemData   = data;
  assign bus.Count     = count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: per-character decode table plus directed load sequences
// on a 16-entry and a 4-entry instance.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.portSize(4), .dataSize(4)) bus ();
  program_loader_if #(.portSize(2), .dataSize(4)) bus2 ();

  program_loader #(.portSize(4), .dataSize(4)) dut (.Clk(clk), .Rst_n(rst_n), .bus(bus.slave));
  program_loader #(.portSize(2), .dataSize(4)) dut2 (.Clk(clk), .Rst_n(rst_n), .bus(bus2.slave));

  logic       start = 1'b0;
  logic       cv    = 1'b0;
  logic [7:0] ch    = 8'h00;
  logic       sel   = 1'b0;
  logic       ready;

  assign bus.Start      = start & ~sel;
  assign bus.CharIn     = ch;
  assign bus.CharValid  = cv & ~sel;
  assign bus2.Start     = start & sel;
  assign bus2.CharIn    = ch;
  assign bus2.CharValid = cv & sel;
  assign ready          = sel ? bus2.CharReady : bus.CharReady;

  // Memory model fed by the write strobes
  logic       clr = 1'b0;
  logic [3:0] mem [16];
  int         wr_cnt, done_cnt, wr_cnt2;
  int         hit2 [4];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
      for (int i = 0; i < 4; i++) hit2[i] <= 0;
      wr_cnt   <= 0;
      wr_cnt2  <= 0;
      done_cnt <= 0;
    end else if (rst_n) begin
      if (bus.MemWrite) begin
        mem[bus.MemAddr] <= bus.MemData;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.Done) done_cnt <= done_cnt + 1;
      if (bus2.MemWrite) begin
        hit2[bus2.MemAddr] <= hit2[bus2.MemAddr] + 1;
        wr_cnt2 <= wr_cnt2 + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    cv    = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one character and returns #1 after the edge that transfers it
  task automatic send(input logic [7:0] c, input bit rnd);
    int  n;
    bit  go;
    n  = 0;
    go = 1'b0;
    @(negedge clk);
    ch = c;
    while (!go && n < 200) begin
      cv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready && cv) go = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!go) check("char_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input string s, input bit rnd);
    for (int i = 0; i < s.len(); i++) send(s[i], rnd);
    cv = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] outs_big();
    return {bus.CharReady, bus.MemWrite, bus.Busy, bus.Done, bus.Error,
            bus.MemAddr, bus.MemData, bus.Count};
  endfunction

  // flags = {MemWrite, Busy, Error, Done, CharReady} one cycle after the transfer
  typedef struct {
    logic [7:0] ch;
    logic [3:0] data;
    logic [4:0] flags;
  } vec_t;

  localparam logic [4:0] F_OP   = 5'b11000;
  localparam logic [4:0] F_SKIP = 5'b01001;
  localparam logic [4:0] F_TERM = 5'b00010;
  localparam logic [4:0] F_ILL  = 5'b00100;

  vec_t vq[$];

  task automatic run_load_035(input bit rnd, input string tag);
    logic [3:0] exp_mem [8];
    exp_mem = '{4'hE, 4'hB, 4'hA, 4'h5, 4'h6, 4'h5, 4'hA, 4'h7};
    do_reset();
    pulse_start();
    stream("DA0<{<0}$", rnd);
    idle_cycles(3);
    check({tag, "_writes"}, 32'(wr_cnt), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_count"}, 32'(bus.Count), 32'd8);
    check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    vq.push_back('{8'h2B, 4'h1, F_OP});
    vq.push_back('{8'h2D, 4'h2, F_OP});
    vq.push_back('{8'h2E, 4'h3, F_OP});
    vq.push_back('{8'h3E, 4'h4, F_OP});
    vq.push_back('{8'h3C, 4'h5, F_OP});
    vq.push_back('{8'h7B, 4'h6, F_OP});
    vq.push_back('{8'h7D, 4'h7, F_OP});
    vq.push_back('{8'h5B, 4'h8, F_OP});
    vq.push_back('{8'h5D, 4'h9, F_OP});
    vq.push_back('{8'h30, 4'hA, F_OP});
    vq.push_back('{8'h41, 4'hB, F_OP});
    vq.push_back('{8'h2C, 4'hC, F_OP});
    vq.push_back('{8'h43, 4'hD, F_OP});
    vq.push_back('{8'h44, 4'hE, F_OP});
    vq.push_back('{8'h48, 4'hF, F_OP});
    vq.push_back('{8'h20, 4'h0, F_SKIP});
    vq.push_back('{8'h09, 4'h0, F_SKIP});
    vq.push_back('{8'h0D, 4'h0, F_SKIP});
    vq.push_back('{8'h0A, 4'h0, F_SKIP});
    vq.push_back('{8'h3B, 4'h0, F_SKIP});
    vq.push_back('{8'h24, 4'h0, F_TERM});
    vq.push_back('{8'h00, 4'h0, F_TERM});
    vq.push_back('{8'h51, 4'h0, F_ILL});
    vq.push_back('{8'h61, 4'h0, F_ILL});
    vq.push_back('{8'h31, 4'h0, F_ILL});
    vq.push_back('{8'hFF, 4'h0, F_ILL});
    vq.push_back('{8'h42, 4'h0, F_ILL});

    // Reset state
    do_reset();
    check("reset_outputs", outs_big(), 32'd0);

    // Per-character decode table
    foreach (vq[i]) begin
      do_reset();
      pulse_start();
      send(vq[i].ch, 1'b0);
      cv = 1'b0;
      check($sformatf("vec_%02h_flags", vq[i].ch),
            32'({bus.MemWrite, bus.Busy, bus.Error, bus.Done, bus.CharReady}), 32'(vq[i].flags));
      check($sformatf("vec_%02h_data", vq[i].ch), 32'(bus.MemData), 32'(vq[i].data));
    end

    // Continuous stream, then the same stream with gapped CharValid
    run_load_035(1'b0, "load");
    run_load_035(1'b1, "gapped");

    // Skips, comment containing a terminator, then real terminator
    do_reset();
    pulse_start();
    stream("+ \n;x$y\n-$", 1'b0);
    idle_cycles(3);
    check("comment_writes", 32'(wr_cnt), 32'd2);
    check("comment_mem0", 32'(mem[0]), 32'd1);
    check("comment_mem1", 32'(mem[1]), 32'd2);
    check("comment_count", 32'(bus.Count), 32'd2);
    check("comment_done", 32'(done_cnt), 32'd1);

    // Illegal character, then recovery by Start
    do_reset();
    pulse_start();
    stream("+Q", 1'b0);
    idle_cycles(1);
    check("illegal_error", 32'(bus.Error), 32'd1);
    check("illegal_ready", 32'(bus.CharReady), 32'd0);
    check("illegal_busy", 32'(bus.Busy), 32'd0);
    check("illegal_writes", 32'(wr_cnt), 32'd1);
    check("illegal_mem0", 32'(mem[0]), 32'd1);
    check("illegal_count", 32'(bus.Count), 32'd1);
    idle_cycles(2);
    check("error_sticky", 32'(bus.Error), 32'd1);
    pulse_start();
    check("restart_error", 32'(bus.Error), 32'd0);
    check("restart_count", 32'(bus.Count), 32'd0);
    check("restart_busy", 32'(bus.Busy), 32'd1);

    // Start during WRITE and RECV is ignored
    do_reset();
    pulse_start();
    send(8'h2B, 1'b0);
    cv = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    stream("-$", 1'b0);
    idle_cycles(3);
    check("start_ign_count", 32'(bus.Count), 32'd2);
    check("start_ign_mem0", 32'(mem[0]), 32'd1);
    check("start_ign_mem1", 32'(mem[1]), 32'd2);
    check("start_ign_done", 32'(done_cnt), 32'd1);

    // Overflow on the 4-entry instance
    do_reset();
    sel = 1'b1;
    pulse_start();
    stream("+++++", 1'b0);
    idle_cycles(1);
    check("ovf_error", 32'(bus2.Error), 32'd1);
    check("ovf_count", 32'(bus2.Count), 32'd4);
    check("ovf_writes", 32'(wr_cnt2), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_hit%0d", i), 32'(hit2[i]), 32'd1);
    check("ovf_memwrite", 32'(bus2.MemWrite), 32'd0);
    sel = 1'b0;

    // Reset (with Start held) during the first write strobe
    do_reset();
    pulse_start();
    send(8'h2B, 1'b0);
    cv = 1'b0;
    check("abort_memwrite_before", 32'(bus.MemWrite), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outputs", outs_big(), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    check("abort_no_write", 32'(wr_cnt), 32'd0);
    pulse_start();
    stream("-$", 1'b0);
    idle_cycles(3);
    check("abort_reload_mem0", 32'(mem[0]), 32'd2);
    check("abort_reload_writes", 32'(wr_cnt), 32'd1);
    check("abort_reload_count", 32'(bus.Count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
